// File: rtl/serial_word_adder.sv
// serial_word_adder
//   Byte-serial adder: one 8-bit ripple-carry add per cycle, with the carry
//   registered between byte slices. A valid/ready handshake accepts an
//   operand set, and the result is held in DONE until the consumer takes it.
//   Define SERIAL_ADDER_OVF_EN to add the signed-overflow output Ovf.
module serial_word_adder #(
    parameter int NBYTES = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                In_Valid,
    output logic                In_Ready,
    input  logic [8*NBYTES-1:0] A,
    input  logic [8*NBYTES-1:0] B,
    input  logic                Cin,
    output logic                Out_Valid,
    input  logic                Out_Ready,
    output logic [8*NBYTES-1:0] S,
    output logic                Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic                Ovf
`endif
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             cin_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;

    // Byte-slice datapath
    logic [7:0] byte_a;
    logic [7:0] byte_b;
    logic       slice_cin;
    logic [8:0] byte_sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic       msb_carry_in;
    logic       ovf_next;
`endif

    // Select the current byte slice and form its 9-bit sum.
    always_comb begin
        byte_a    = a_reg[{idx, 3'b000} +: 8];
        byte_b    = b_reg[{idx, 3'b000} +: 8];
        // Byte 0 starts from the captured carry-in; later bytes chain the
        // carry registered on the previous cycle.
        slice_cin = (idx == '0) ? cin_reg : carry;
        byte_sum  = {1'b0, byte_a} + {1'b0, byte_b} + {8'd0, slice_cin};
`ifdef SERIAL_ADDER_OVF_EN
        // The carry into bit 7 is recovered from the sum bit and the operand bits.
        msb_carry_in = byte_a[7] ^ byte_b[7] ^ byte_sum[7];
        ovf_next     = msb_carry_in ^ byte_sum[8];
`endif
    end

    // Control FSM with registered handshake and result outputs.
    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, regardless of statement order inside the block.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            // NOTE: reset clears the operand registers as well as the control
            // state, so an aborted operation leaves nothing behind.
            state     <= IDLE;
            In_Ready  <= 1'b1;
            Out_Valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            cin_reg   <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
            S         <= '0;
            Cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (In_Valid) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        cin_reg  <= Cin;
                        carry    <= 1'b0;
                        idx      <= '0;
                        S        <= '0;
                        Cout     <= 1'b0;
                        In_Ready <= 1'b0;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    S[{idx, 3'b000} +: 8] <= byte_sum[7:0];
                    carry                 <= byte_sum[8];
                    if (idx == LAST_IDX) begin
                        Cout      <= byte_sum[8];
`ifdef SERIAL_ADDER_OVF_EN
                        Ovf       <= ovf_next;
`endif
                        Out_Valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    // Result holds until the consumer takes it.
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        In_Ready  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        Ovf       <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    In_Ready  <= 1'b1;
                    Out_Valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
